slave_read: RTL and testbench

- AHB-Lite read-side slave for the encryption accelerator; counterpart to the write-side slave that loads key/nonce/plain text.
- Services single-word reads of a status word, the four ciphertext words at the head of the output FIFO, and a completed-block counter.
- Reading the last ciphertext word pops the FIFO.
- Drives HREADYOUT/HRESP equivalents (read_ready, read_error), including wait states and the two-cycle AHB ERROR response.

---
 rtl/slave_read_if.sv | 26 ++
 rtl/slave_read.sv | 130 +++++++++++++
 tb/tb_slave_read.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/slave_read_if.sv
// AHB-Lite read-side bus bundle for slave_read.
// Carries the address-phase controls from the master (HSELx, HADDR, HTRANS,
// HWRITE, HSIZE, HBURST, HREADY) and the slave's data-phase response
// (HRDATA, read_ready = HREADYOUT, read_error = HRESP).
interface slave_read_if;
  logic        HSELx;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        read_ready;
  logic        read_error;

  modport master (
    output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY,
    input  HRDATA, read_ready, read_error
  );

  modport slave (
    input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY,
    output HRDATA, read_ready, read_error
  );
endinterface

// File: rtl/slave_read.sv
// AHB-Lite read-side slave of the encryption accelerator.
// Serves single-word reads of the status word (0x44), the four ciphertext
// words at the output FIFO head (0x48..0x54) and the popped-block counter
// (0x58). Reading 0x54 pops the FIFO. Ciphertext reads on an empty FIFO
// stall up to WAIT_MAX cycles, then take the two-cycle ERROR response.
// Ports:
//   HCLK, HRESETn     clock, async active-low reset
//   bus               AHB slave modport (address phase in, response out)
//   fifo_empty        output FIFO empty
//   fifo_rdata        head ciphertext block, word0 in [31:0]
//   core_busy         AES core busy
//   core_error        AES core sticky error
//   fifo_pop          one-cycle pop strobe on a completed 0x54 read
module slave_read #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  slave_read_if.slave   bus,
  input  logic          fifo_empty,
  input  logic [127:0]  fifo_rdata,
  input  logic          core_busy,
  input  logic          core_error,
  output logic          fifo_pop
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t           state, state_n;
  logic [7:0]       addr_q;
  logic [7:0]       stall_q, stall_n;
  logic [CNT_W-1:0] cnt_q;

  logic        accept, legal, complete, is_cipher;
  logic [31:0] word;
  logic        unused_bits;

  // Upper address bits and HTRANS[0] carry no meaning for this block.
  assign unused_bits = ^{bus.HADDR[31:8], bus.HTRANS[0]};

  assign accept = bus.HSELx & bus.HREADY & bus.HTRANS[1] & ~bus.HWRITE;
  assign legal  = (bus.HSIZE == 3'b010) && (bus.HBURST == 3'd0) &&
                  (bus.HADDR[1:0] == 2'b00) &&
                  (bus.HADDR[7:0] >= 8'h44) && (bus.HADDR[7:0] <= 8'h58);

  assign is_cipher = (addr_q == 8'h48) || (addr_q == 8'h4C) ||
                     (addr_q == 8'h50) || (addr_q == 8'h54);

  // Read mux over the captured offset; fed from live FIFO/core inputs so a
  // stalled read returns whatever head block is present when it completes.
  always_comb begin
    word = 32'h0;
    case (addr_q)
      8'h44:   word = {29'b0, fifo_empty, core_busy, core_error};
      8'h48:   word = fifo_rdata[31:0];
      8'h4C:   word = fifo_rdata[63:32];
      8'h50:   word = fifo_rdata[95:64];
      8'h54:   word = fifo_rdata[127:96];
      8'h58:   word = 32'(cnt_q);
      default: word = 32'h0;
    endcase
  end

  always_comb begin
    state_n        = state;
    stall_n        = stall_q;
    complete       = 1'b0;
    fifo_pop       = 1'b0;
    bus.HRDATA     = 32'h0;
    bus.read_ready = 1'b1;
    bus.read_error = 1'b0;
    case (state)
      S_IDLE: complete = 1'b1;
      S_DATA: begin
        if (is_cipher && fifo_empty) begin
          // First stall cycle is this one; WAIT covers the rest.
          bus.read_ready = 1'b0;
          stall_n        = 8'd1;
          state_n        = (WAIT_MAX <= 1) ? S_ERR1 : S_WAIT;
        end else begin
          complete   = 1'b1;
          bus.HRDATA = word;
          fifo_pop   = (addr_q == 8'h54);
        end
      end
      S_WAIT: begin
        if (fifo_empty) begin
          bus.read_ready = 1'b0;
          if ((9'(stall_q) + 9'd1) >= 9'(WAIT_MAX)) state_n = S_ERR1;
          else                                      stall_n = stall_q + 8'd1;
        end else begin
          complete   = 1'b1;
          bus.HRDATA = word;
          fifo_pop   = (addr_q == 8'h54);
        end
      end
      S_ERR1: begin
        bus.read_ready = 1'b0;
        bus.read_error = 1'b1;
        state_n        = S_ERR2;
      end
      S_ERR2: begin
        bus.read_error = 1'b1;
        complete       = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    // A completing cycle doubles as the next address phase.
    if (complete) begin
      if (accept) state_n = legal ? S_DATA : S_ERR1;
      else        state_n = S_IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      addr_q  <= 8'h0;
      stall_q <= 8'h0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      stall_q <= stall_n;
      if (complete && accept) addr_q <= bus.HADDR[7:0];
      if (fifo_pop)           cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_slave_read.sv
// Bench for slave_read: table of directed transfers with explicit expected
// responses, hand-written sequences for non-accepted transfers, counter wrap
// and mid-transfer reset, then randomized transfers checked against a
// transaction-level model (stall count / error / data / pop per transfer).
module tb_slave_read;
  localparam int WM = 16;
  localparam int CW = 4;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    int          delay;      // data-phase cycles the FIFO stays empty
    int          exp_stall;  // ready=0/err=0 cycles before the response
    bit          exp_err;
    logic [31:0] exp_data;
    bit          exp_pop;
  } rec_t;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         fifo_empty, core_busy, core_error, fifo_pop;
  logic [127:0] fifo_rdata;

  int checks = 0;
  int errors = 0;
  int mdl_cnt = 0;

  slave_read_if bus_if();

  slave_read #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_if),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .core_busy(core_busy), .core_error(core_error), .fifo_pop(fifo_pop)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [34:0] e);
    logic [34:0] a;
    a = {bus_if.read_ready, bus_if.read_error, fifo_pop, bus_if.HRDATA};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got rdy=%0b err=%0b pop=%0b data=%08h, want rdy=%0b err=%0b pop=%0b data=%08h",
               tag, a[34], a[33], a[32], a[31:0], e[34], e[33], e[32], e[31:0]);
    end
  endtask

  task automatic bus_idle();
    bus_if.HSELx = 1'b0; bus_if.HTRANS = 2'd0; bus_if.HWRITE = 1'b0;
    bus_if.HREADY = 1'b1;
  endtask

  // Drives the address phase now (called off the rising edge), follows the
  // data phase cycle by cycle and returns at the falling edge of the cycle
  // the response completes, so a following call pipelines back-to-back.
  task automatic xfer(input string tag, input rec_t r);
    int k;
    bit done;
    logic [34:0] e;
    bus_if.HSELx = 1'b1; bus_if.HTRANS = 2'd2; bus_if.HWRITE = 1'b0;
    bus_if.HADDR = r.addr; bus_if.HSIZE = r.size; bus_if.HBURST = r.burst;
    bus_if.HREADY = 1'b1;
    @(posedge HCLK); #1;
    bus_idle();
    fifo_empty = (r.delay > 0);
    k = 0; done = 0;
    while (!done) begin
      @(negedge HCLK);
      if (k < r.exp_stall)    e = {3'b000, 32'h0};
      else if (!r.exp_err)    begin e = {1'b1, 1'b0, r.exp_pop, r.exp_data}; done = 1; end
      else if (k == r.exp_stall) e = {3'b010, 32'h0};
      else                    begin e = {3'b110, 32'h0}; done = 1; end
      chk(tag, e);
      if (!done) begin
        @(posedge HCLK); #1;
        fifo_empty = (k + 1 < r.delay);
      end
      k++;
    end
    if (r.exp_pop) mdl_cnt = (mdl_cnt + 1) % (1 << CW);
  endtask

  // Transaction-level reference: what a transfer should return given the
  // address map, legality rules, FIFO-empty time and current FIFO/core state.
  function automatic rec_t build(input logic [31:0] a, input logic [2:0] sz,
                                 input logic [2:0] bu, input int d);
    rec_t r;
    logic [7:0] o;
    bit legal;
    o = a[7:0];
    r.addr = a; r.size = sz; r.burst = bu; r.delay = d;
    r.exp_stall = 0; r.exp_err = 0; r.exp_data = 32'h0; r.exp_pop = 0;
    legal = (sz == 3'd2) && (bu == 3'd0) && (o % 4 == 0) && (o >= 8'h44) && (o <= 8'h58);
    if (!legal)              r.exp_err = 1;
    else if (o == 8'h44)     r.exp_data = {29'b0, (d > 0), core_busy, core_error};
    else if (o == 8'h58)     r.exp_data = 32'(mdl_cnt);
    else if (d >= WM)        begin r.exp_stall = WM; r.exp_err = 1; end
    else begin
      r.exp_stall = d;
      r.exp_data  = 32'(fifo_rdata >> (32 * ((int'(o) - 'h48) / 4)));
      r.exp_pop   = (o == 8'h54);
    end
    return r;
  endfunction

  rec_t tbl[14];
  logic [3:0] na_pat[5];  // {HSELx, HTRANS, HWRITE}, plus HREADY=0 case

  initial begin
    rec_t r;
    int idx, d;
    logic [7:0] o;
    logic [2:0] sz, bu;

    HRESETn = 1'b0;
    fifo_empty = 1'b0; core_busy = 1'b1; core_error = 1'b0;
    fifo_rdata = 128'h33333333_22222222_11111111_00000000;
    bus_if.HADDR = 32'h0; bus_if.HSIZE = 3'd2; bus_if.HBURST = 3'd0;
    bus_idle();

    tbl[0]  = '{32'h44, 3'd2, 3'd0, 1,  0,  0, 32'h00000006, 0};
    tbl[1]  = '{32'h48, 3'd2, 3'd0, 0,  0,  0, 32'h00000000, 0};
    tbl[2]  = '{32'h4C, 3'd2, 3'd0, 0,  0,  0, 32'h11111111, 0};
    tbl[3]  = '{32'h50, 3'd2, 3'd0, 0,  0,  0, 32'h22222222, 0};
    tbl[4]  = '{32'h54, 3'd2, 3'd0, 0,  0,  0, 32'h33333333, 1};
    tbl[5]  = '{32'h58, 3'd2, 3'd0, 0,  0,  0, 32'h00000001, 0};
    tbl[6]  = '{32'h54, 3'd2, 3'd0, 3,  3,  0, 32'h33333333, 1};
    tbl[7]  = '{32'h4C, 3'd2, 3'd0, 15, 15, 0, 32'h11111111, 0};
    tbl[8]  = '{32'h48, 3'd2, 3'd0, 20, 16, 1, 32'h00000000, 0};
    tbl[9]  = '{32'h46, 3'd2, 3'd0, 0,  0,  1, 32'h00000000, 0};
    tbl[10] = '{32'h44, 3'd2, 3'd3, 0,  0,  1, 32'h00000000, 0};
    tbl[11] = '{32'h60, 3'd2, 3'd0, 0,  0,  1, 32'h00000000, 0};
    tbl[12] = '{32'h44, 3'd0, 3'd0, 0,  0,  1, 32'h00000000, 0};
    tbl[13] = '{32'h58, 3'd2, 3'd0, 0,  0,  0, 32'h00000002, 0};

    #12 chk("reset", {3'b100, 32'h0});
    @(negedge HCLK); HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // Directed table, back-to-back
    for (int i = 0; i < 14; i++) xfer($sformatf("tbl%0d", i), tbl[i]);

    // Transfers that must not be accepted
    na_pat[0] = 4'b1_10_1; na_pat[1] = 4'b1_00_0; na_pat[2] = 4'b1_01_0;
    na_pat[3] = 4'b0_10_0; na_pat[4] = 4'b1_10_0;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      bus_if.HSELx = na_pat[i][3]; bus_if.HTRANS = na_pat[i][2:1];
      bus_if.HWRITE = na_pat[i][0]; bus_if.HADDR = 32'h48;
      bus_if.HREADY = (i != 4);
      @(posedge HCLK); #1;
      bus_idle();
      @(negedge HCLK);
      chk($sformatf("noaccept%0d", i), {3'b100, 32'h0});
    end
    xfer("cnt_after_noaccept", build(32'h58, 3'd2, 3'd0, 0));

    // Counter wrap 15 -> 0
    while (mdl_cnt != (1 << CW) - 1) xfer("wrap_fill", build(32'h54, 3'd2, 3'd0, 0));
    xfer("cnt_max", build(32'h58, 3'd2, 3'd0, 0));
    xfer("wrap_pop", build(32'h54, 3'd2, 3'd0, 0));
    xfer("cnt_wrapped", build(32'h58, 3'd2, 3'd0, 0));

    // Randomized transfers against the model
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 9);
      if (idx < 6)       o = 8'(8'h44 + 4 * idx);
      else if (idx == 6) o = 8'($urandom) | 8'h01;
      else if (idx == 7) o = 8'h5C;
      else if (idx == 8) o = 8'h40;
      else               o = 8'($urandom);
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      bu = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      d  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      core_busy  = 1'($urandom_range(0, 1));
      core_error = 1'($urandom_range(0, 1));
      r = build({24'($urandom), o}, sz, bu, d);
      xfer($sformatf("rand%0d", n), r);
      if (r.exp_pop) fifo_rdata = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge HCLK);
    end

    // Reset while stalled in WAIT
    @(negedge HCLK);
    bus_if.HSELx = 1'b1; bus_if.HTRANS = 2'd2; bus_if.HWRITE = 1'b0;
    bus_if.HADDR = 32'h54; bus_if.HSIZE = 3'd2; bus_if.HBURST = 3'd0;
    @(posedge HCLK); #1;
    bus_idle(); fifo_empty = 1'b1;
    repeat (5) begin
      @(negedge HCLK);
      chk("wait_stall", {3'b000, 32'h0});
    end
    #2 HRESETn = 1'b0;
    #1 chk("reset_in_wait", {3'b100, 32'h0});
    @(posedge HCLK); #1 HRESETn = 1'b1; fifo_empty = 1'b0;
    mdl_cnt = 0;
    @(negedge HCLK);
    xfer("cnt_after_reset", build(32'h58, 3'd2, 3'd0, 0));

    // Reset in ERR1
    @(negedge HCLK);
    bus_if.HSELx = 1'b1; bus_if.HTRANS = 2'd2; bus_if.HADDR = 32'h60;
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    chk("err1", {3'b010, 32'h0});
    #2 HRESETn = 1'b0;
    #1 chk("reset_in_err1", {3'b100, 32'h0});
    @(posedge HCLK); #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("idle_after_reset", {3'b100, 32'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
